tcm_axis_burst_ctrl: RTL and testbench
======================================

// Module: tcm_axis_burst_ctrl
// PURPOSE
//  Sequences AXI-Stream ingestion into a single-port TCM, one programmed burst per start command.
//  Each accepted beat is written to TCM at base + index.
//  Shares the TCM port with a host read requester under fixed priority; the host always wins.
//  Sits between the AXIS slave interface and the TCM macro, driven by the user control word.
// PARAMETERS
//  C_S_AXIS_TDATA_WIDTH  32  stream/TCM data width, multiple of 8
//  C_TCM_ADDR_WIDTH      10  TCM word address width
// PORTS
//  S_AXIS_ACLK       in   1    sole clock
//  S_AXIS_ARESET     in   1    asynchronous, active-high reset
//  USR_tcm_control   in   32   [0] start (rising edge), [1] abort (level), [15:8] len-1, [31:16] base word addr
//  S_AXIS_TREADY     out  1    stream ready
//  S_AXIS_TDATA      in   W    stream data
//  S_AXIS_TSTRB      in   W/8  byte strobes
//  S_AXIS_TLAST      in   1    end of packet
//  S_AXIS_TVALID     in   1    stream valid
//  USR_host_req      in   1    host read request (one cycle per read)
//  USR_host_addr     in   AW   host read word address
//  USR_host_rdata    out  W    host read data
//  USR_host_rvalid   out  1    host read data valid
//  USR_tcm_en        out  1    TCM enable
//  USR_tcm_we        out  W/8  TCM byte write enables
//  USR_tcm_addr      out  AW   TCM address
//  USR_tcm_wdata     out  W    TCM write data
//  USR_tcm_rdata     in   W    TCM read data, 1-cycle synchronous read
//  USR_tcm_status    out  32   [0] busy, [1] done, [2] early_last, [3] missing_last, [4] aborted, [23:8] beats written
//  USR_irq           out  1    one-cycle pulse on burst completion or error
// BEHAVIOUR
//  Reset: state=IDLE; TREADY=0, tcm_en=0, tcm_we=0, host_rvalid=0, irq=0, status=0; addr/wdata/rdata=0.
//  Start detection: start_d registers control[0]; start_pulse = control[0] & ~start_d.
//  FSM IDLE:
//   - start_pulse & ~abort -> RUN.
//   - Latch len = control[15:8]+1 (1..256) and base = control[31:16] truncated to AW.
//   - Clear status[4:1] and the beat count.
//   - Start and abort in the same cycle -> stay in IDLE.
//  FSM RUN:
//   - TREADY = ~USR_host_req. The TCM port is combinational from the handshake.
//   - Beat accepted (TVALID & TREADY): tcm_en=1, tcm_we=all-ones, tcm_addr=(base+cnt) mod 2^AW (address wraps silently), wdata=TDATA, cnt++.
//   - TLAST on a beat with cnt<len-1 -> set early_last, go to DONE.
//   - Beat with cnt==len-1 -> go to DONE; set missing_last if TLAST=0 on that beat.
//   - abort=1 -> IDLE with aborted=1 and irq pulse. A beat in the same cycle is not accepted: TREADY is gated by ~abort.
//  FSM DONE: one cycle; done=1, irq=1, TREADY=0 -> IDLE. done and error bits stay sticky until the next start.
//  busy = (state==RUN). status[23:8] = cnt, zero-extended.
//  Host arbitration:
//   - USR_host_req=1 in any state -> tcm_en=1, we=0, addr=host_addr; the stream stalls that cycle.
//   - host_rvalid=1 and host_rdata=tcm_rdata in the next cycle (latency 1).
//   - Back-to-back host requests are allowed and starve the stream.
//  A start_pulse while in RUN or DONE is ignored.
//  Asynchronous reset mid-burst: immediately IDLE, all outputs return to reset values, and the partial burst is discarded.
// CONFIGURATION
//  TCM_AXIS_BYTE_STROBE_EN
//   - Defined: tcm_we = S_AXIS_TSTRB on accepted beats. A beat with TSTRB=0 still counts but writes no bytes.
//   - Undefined: tcm_we = all-ones on accepted beats, and TSTRB is ignored.
// TESTING
//  1. ctrl base=0x010, len-1=3, start; 4 beats D0..D3 with TLAST on D3 -> writes at 0x010..0x013, done=1, status[23:8]=4, one irq pulse.
//  2. len-1=7; TLAST on 3rd beat -> 3 writes, early_last=1, done=1, TREADY=0 afterwards.
//  3. len-1=1; 2 beats, no TLAST -> missing_last=1, done=1; next start clears both flags.
//  4. Burst running, host_req on addr 0x012 for 2 cycles -> TREADY=0 for those cycles; rvalid 1 cycle after each request, carrying the TCM data; no beat is lost.
//  5. base=0x3FE, len-1=3 -> writes at 0x3FE, 0x3FF, 0x000, 0x001.
//  6. Abort after 2 of 8 beats -> IDLE, aborted=1, irq pulse, cnt=2; reset asserted mid-burst -> all outputs at reset values the same cycle.

Source files
------------

// File: rtl/tcm_axis_burst_ctrl_if.sv
// ---------------------------------------------------------------------------
// tcm_axis_burst_ctrl_if
//   AXI-Stream handshake bundle feeding the TCM burst controller.
//
//   Parameters
//     C_S_AXIS_TDATA_WIDTH : stream data width in bits, a multiple of 8
//
//   Signals
//     S_AXIS_TREADY : sink -> source, sink can take a beat this cycle
//     S_AXIS_TDATA  : source -> sink, beat payload
//     S_AXIS_TSTRB  : source -> sink, byte strobes (one per data byte)
//     S_AXIS_TLAST  : source -> sink, last beat of the packet
//     S_AXIS_TVALID : source -> sink, beat is valid
//
//   Modports
//     master : stream source (drives data/valid, observes ready)
//     slave  : stream sink (the burst controller)
// ---------------------------------------------------------------------------
interface tcm_axis_burst_ctrl_if #(
  parameter int C_S_AXIS_TDATA_WIDTH = 32
);

  logic                                S_AXIS_TREADY;
  logic [C_S_AXIS_TDATA_WIDTH-1:0]     S_AXIS_TDATA;
  logic [C_S_AXIS_TDATA_WIDTH/8-1:0]   S_AXIS_TSTRB;
  logic                                S_AXIS_TLAST;
  logic                                S_AXIS_TVALID;

  modport master (
    output S_AXIS_TDATA,
    output S_AXIS_TSTRB,
    output S_AXIS_TLAST,
    output S_AXIS_TVALID,
    input  S_AXIS_TREADY
  );

  modport slave (
    input  S_AXIS_TDATA,
    input  S_AXIS_TSTRB,
    input  S_AXIS_TLAST,
    input  S_AXIS_TVALID,
    output S_AXIS_TREADY
  );

endinterface

// File: rtl/tcm_axis_burst_ctrl.sv
// ---------------------------------------------------------------------------
// tcm_axis_burst_ctrl
//   Sequences AXI-Stream ingestion into a single-port TCM, one programmed
//   burst per start command. Each accepted beat is written at base + index
//   (word address, wrapping modulo the TCM size). The TCM port is shared with
//   a host read requester; the host always wins and the stream stalls.
//
//   Parameters
//     C_S_AXIS_TDATA_WIDTH : stream / TCM data width, multiple of 8 (W)
//     C_TCM_ADDR_WIDTH     : TCM word address width (AW), at most 16
//
//   Ports
//     S_AXIS_ACLK      in   1     sole clock
//     S_AXIS_ARESET    in   1     asynchronous, active-high reset
//     USR_tcm_control  in   32    [0] start (rising edge), [1] abort (level),
//                                 [15:8] len-1, [31:16] base word address
//     s_axis           slave      AXIS beat handshake (TREADY/TDATA/TSTRB/
//                                 TLAST/TVALID)
//     USR_host_req     in   1     host read request, one cycle per read
//     USR_host_addr    in   AW    host read word address
//     USR_host_rdata   out  W     host read data (valid with rvalid)
//     USR_host_rvalid  out  1     host read data valid, 1 cycle after request
//     USR_tcm_en       out  1     TCM enable
//     USR_tcm_we       out  W/8   TCM byte write enables
//     USR_tcm_addr     out  AW    TCM word address
//     USR_tcm_wdata    out  W     TCM write data
//     USR_tcm_rdata    in   W     TCM read data, 1-cycle synchronous read
//     USR_tcm_status   out  32    [0] busy, [1] done, [2] early_last,
//                                 [3] missing_last, [4] aborted,
//                                 [23:8] beats written in current burst
//     USR_irq          out  1     one-cycle pulse on completion or abort
//
//   Build option
//     TCM_AXIS_BYTE_STROBE_EN : when defined, accepted beats write only the
//       bytes flagged in TSTRB (a zero strobe still counts as a beat). When
//       undefined, every accepted beat writes the full word and TSTRB is
//       ignored.
// ---------------------------------------------------------------------------
module tcm_axis_burst_ctrl #(
  parameter int C_S_AXIS_TDATA_WIDTH = 32,
  parameter int C_TCM_ADDR_WIDTH     = 10
) (
  input  logic                                S_AXIS_ACLK,
  input  logic                                S_AXIS_ARESET,
  input  logic [31:0]                         USR_tcm_control,
  tcm_axis_burst_ctrl_if.slave                s_axis,
  input  logic                                USR_host_req,
  input  logic [C_TCM_ADDR_WIDTH-1:0]         USR_host_addr,
  output logic [C_S_AXIS_TDATA_WIDTH-1:0]     USR_host_rdata,
  output logic                                USR_host_rvalid,
  output logic                                USR_tcm_en,
  output logic [C_S_AXIS_TDATA_WIDTH/8-1:0]   USR_tcm_we,
  output logic [C_TCM_ADDR_WIDTH-1:0]         USR_tcm_addr,
  output logic [C_S_AXIS_TDATA_WIDTH-1:0]     USR_tcm_wdata,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0]     USR_tcm_rdata,
  output logic [31:0]                         USR_tcm_status,
  output logic                                USR_irq
);

  localparam int W  = C_S_AXIS_TDATA_WIDTH;
  localparam int SW = C_S_AXIS_TDATA_WIDTH / 8;
  localparam int AW = C_TCM_ADDR_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic          start_d;
  logic          start_pulse;
  logic          abort_req;
  logic          host_grant;
  logic          beat_acc;
  logic          last_slot;
  logic          burst_end;

  // len_q holds len (1..256), so it needs one bit more than the len-1 field
  logic [8:0]    len_q;
  logic [8:0]    cnt_q;
  logic [AW-1:0] base_q;
  logic [AW-1:0] beat_addr;

  logic          done_q;
  logic          early_q;
  logic          missing_q;
  logic          aborted_q;
  logic          irq_q;
  logic          rvalid_q;

  logic [SW-1:0] beat_we;
  logic          unused_bits;

  assign start_pulse = USR_tcm_control[0] & ~start_d;
  assign abort_req   = USR_tcm_control[1];

  // The host port is held quiet while reset is asserted so that every output
  // sits at its reset value for the whole reset interval, not just the
  // registered ones.
  assign host_grant  = USR_host_req & ~S_AXIS_ARESET;

  // A beat is taken only in RUN, only when the host is not using the port
  // and not in an abort cycle. This matches the TREADY the source sees.
  assign beat_acc    = (state == ST_RUN) & s_axis.S_AXIS_TVALID
                     & ~USR_host_req & ~abort_req;

  assign last_slot   = (cnt_q == (len_q - 9'd1));
  assign burst_end   = beat_acc & (last_slot | s_axis.S_AXIS_TLAST);

  // Address wraps silently at the top of the TCM
  assign beat_addr   = base_q + AW'(cnt_q);

`ifdef TCM_AXIS_BYTE_STROBE_EN
  assign beat_we     = s_axis.S_AXIS_TSTRB;
  assign unused_bits = ^{USR_tcm_control[7:2], USR_tcm_control[31:16]};
`else
  assign beat_we     = '1;
  assign unused_bits = ^{USR_tcm_control[7:2], USR_tcm_control[31:16],
                         s_axis.S_AXIS_TSTRB};
`endif

  // State register
  always_ff @(posedge S_AXIS_ACLK or posedge S_AXIS_ARESET) begin
    if (S_AXIS_ARESET) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. A start coinciding with abort is dropped; starts seen
  // in RUN or DONE are ignored because only IDLE looks at start_pulse.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (start_pulse && !abort_req) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort_req) begin
          state_nxt = ST_IDLE;
        end else if (burst_end) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Output logic. The TCM port is combinational from the handshake; the host
  // path takes precedence over a stream write.
  always_comb begin
    s_axis.S_AXIS_TREADY = 1'b0;
    USR_tcm_en           = 1'b0;
    USR_tcm_we           = '0;
    USR_tcm_addr         = '0;
    USR_tcm_wdata        = '0;

    if (state == ST_RUN) begin
      s_axis.S_AXIS_TREADY = ~USR_host_req & ~abort_req;
    end

    if (host_grant) begin
      USR_tcm_en   = 1'b1;
      USR_tcm_addr = USR_host_addr;
    end else if (beat_acc) begin
      USR_tcm_en    = 1'b1;
      USR_tcm_we    = beat_we;
      USR_tcm_addr  = beat_addr;
      USR_tcm_wdata = s_axis.S_AXIS_TDATA;
    end
  end

  // Burst bookkeeping: latches the programmed length/base on start, counts
  // beats, and keeps the done/error flags sticky until the next start.
  always_ff @(posedge S_AXIS_ACLK or posedge S_AXIS_ARESET) begin
    if (S_AXIS_ARESET) begin
      start_d   <= 1'b0;
      len_q     <= 9'd0;
      base_q    <= '0;
      cnt_q     <= 9'd0;
      done_q    <= 1'b0;
      early_q   <= 1'b0;
      missing_q <= 1'b0;
      aborted_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      start_d <= USR_tcm_control[0];
      irq_q   <= 1'b0;

      unique case (state)
        ST_IDLE: begin
          if (start_pulse && !abort_req) begin
            len_q     <= {1'b0, USR_tcm_control[15:8]} + 9'd1;
            base_q    <= USR_tcm_control[16 +: AW];
            cnt_q     <= 9'd0;
            done_q    <= 1'b0;
            early_q   <= 1'b0;
            missing_q <= 1'b0;
            aborted_q <= 1'b0;
          end
        end
        ST_RUN: begin
          if (abort_req) begin
            aborted_q <= 1'b1;
            irq_q     <= 1'b1;
          end else if (beat_acc) begin
            cnt_q <= cnt_q + 9'd1;
            if (s_axis.S_AXIS_TLAST && !last_slot) begin
              early_q <= 1'b1;
            end
            if (last_slot && !s_axis.S_AXIS_TLAST) begin
              missing_q <= 1'b1;
            end
            // done is raised on entry so it is already visible in DONE
            if (burst_end) begin
              done_q <= 1'b1;
              irq_q  <= 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Host read return: the TCM answers one cycle after the request, so the
  // valid is just the request delayed and the data passes straight through.
  always_ff @(posedge S_AXIS_ACLK or posedge S_AXIS_ARESET) begin
    if (S_AXIS_ARESET) begin
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= USR_host_req;
    end
  end

  assign USR_host_rvalid = rvalid_q;
  assign USR_host_rdata  = rvalid_q ? USR_tcm_rdata : {W{1'b0}};
  assign USR_irq         = irq_q;

  assign USR_tcm_status  = {8'd0, 7'd0, cnt_q, 3'd0,
                            aborted_q, missing_q, early_q, done_q,
                            (state == ST_RUN)};

endmodule

// File: tb/tb_tcm_axis_burst_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tcm_axis_burst_ctrl
//   Randomised bench for tcm_axis_burst_ctrl. A behavioural TCM sits on the
//   memory port. Stimulus pushes expected TCM writes, host reads and read
//   data into queues; a monitor pops and compares whenever the DUT drives the
//   TCM port or returns host data. Burst outcomes (beat count, flags, irq
//   count) come from a small reference computed from the burst parameters.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_tcm_axis_burst_ctrl;

  localparam int W  = 32;
  localparam int SW = W / 8;
  localparam int AW = 10;
  localparam int DEPTH = 1 << AW;

  logic          aclk = 1'b0;
  logic          areset;
  logic [31:0]   ctrl;
  logic          host_req;
  logic [AW-1:0] host_addr;
  logic [W-1:0]  host_rdata;
  logic          host_rvalid;
  logic          tcm_en;
  logic [SW-1:0] tcm_we;
  logic [AW-1:0] tcm_addr;
  logic [W-1:0]  tcm_wdata;
  logic [W-1:0]  tcm_rdata;
  logic [31:0]   status;
  logic          irq;
  logic          mem_init;

  tcm_axis_burst_ctrl_if #(.C_S_AXIS_TDATA_WIDTH(W)) axis ();

  tcm_axis_burst_ctrl #(
    .C_S_AXIS_TDATA_WIDTH(W),
    .C_TCM_ADDR_WIDTH(AW)
  ) dut (
    .S_AXIS_ACLK    (aclk),
    .S_AXIS_ARESET  (areset),
    .USR_tcm_control(ctrl),
    .s_axis         (axis),
    .USR_host_req   (host_req),
    .USR_host_addr  (host_addr),
    .USR_host_rdata (host_rdata),
    .USR_host_rvalid(host_rvalid),
    .USR_tcm_en     (tcm_en),
    .USR_tcm_we     (tcm_we),
    .USR_tcm_addr   (tcm_addr),
    .USR_tcm_wdata  (tcm_wdata),
    .USR_tcm_rdata  (tcm_rdata),
    .USR_tcm_status (status),
    .USR_irq        (irq)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
    logic [SW-1:0] we;
  } wr_t;

  wr_t           exp_wr_q[$];
  logic [AW-1:0] exp_rd_addr_q[$];
  logic [W-1:0]  exp_rd_data_q[$];
  logic [W-1:0]  tcm_mem [0:DEPTH-1];
  logic [W-1:0]  ref_mem [0:DEPTH-1];

  int tests_run    = 0;
  int tests_failed = 0;
  int irq_seen     = 0;
  int irq_expected = 0;

  function automatic logic [W-1:0] initWord(input int a);
    return W'(a) * 32'h9E37_79B1 ^ 32'h5A5A_0000;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic reportFail(input string name, input string detail);
    tests_run++;
    tests_failed++;
    $display("[TB] FAIL %s: %s", name, detail);
  endtask

  // Behavioural single-port TCM with one-cycle read latency
  always @(posedge aclk) begin
    if (mem_init) begin
      for (int i = 0; i < DEPTH; i++) tcm_mem[i] <= initWord(i);
    end else if (tcm_en) begin
      for (int b = 0; b < SW; b++)
        if (tcm_we[b]) tcm_mem[tcm_addr][8*b +: 8] <= tcm_wdata[8*b +: 8];
      tcm_rdata <= tcm_mem[tcm_addr];
    end
  end

  // Monitor: mid-cycle sampling of the TCM port and host return path
  always @(negedge aclk) begin
    if (!areset) begin
      if (host_req) begin
        checkOutput("host_en", tcm_en, 1'b1);
        checkOutput("host_we", tcm_we, '0);
        if (exp_rd_addr_q.size() == 0) reportFail("host_addr", "no read expected");
        else checkOutput("host_addr", tcm_addr, exp_rd_addr_q.pop_front());
      end else if (tcm_en) begin
        if (exp_wr_q.size() == 0) begin
          reportFail("unexpected_write", $sformatf("addr 0x%0h data 0x%0h, required no access",
                                                   tcm_addr, tcm_wdata));
        end else begin
          wr_t e;
          e = exp_wr_q.pop_front();
          checkOutput("wr_addr", tcm_addr, e.addr);
          checkOutput("wr_data", tcm_wdata, e.data);
          checkOutput("wr_we", tcm_we, e.we);
        end
      end
      if (host_rvalid) begin
        if (exp_rd_data_q.size() == 0) reportFail("host_rvalid", "no read data expected");
        else checkOutput("host_rdata", host_rdata, exp_rd_data_q.pop_front());
      end
      if (irq) irq_seen++;
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic pushBeat(input logic [AW-1:0] a, input logic [W-1:0] d,
                          input logic [SW-1:0] s);
    logic [SW-1:0] w;
`ifdef TCM_AXIS_BYTE_STROBE_EN
    w = s;
`else
    w = '1;
    if (s == '0) w = '1;
`endif
    exp_wr_q.push_back('{addr: a, data: d, we: w});
    for (int b = 0; b < SW; b++)
      if (w[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic pushHostRead(input logic [AW-1:0] a);
    exp_rd_addr_q.push_back(a);
    exp_rd_data_q.push_back(ref_mem[a]);
  endtask

  // One programmed burst. tlast_idx < 0: no TLAST; abort_after < 0: no abort.
  task automatic applyStimulus(input logic [AW-1:0] base, input int len_m1,
                               input int tlast_idx, input int abort_after,
                               input int host_pct, input int host_fixed);
    int len, n_exp, beat, cycles;
    bit finished, abort_now, acc, tv;
    bit early_e, missing_e, aborted_e;
    logic [31:0] base_field, exp_status;

    len = len_m1 + 1;
    early_e = 0; missing_e = 0; aborted_e = 0;
    if (abort_after >= 0) begin
      n_exp = abort_after; aborted_e = 1;
    end else if (tlast_idx >= 0 && tlast_idx < len - 1) begin
      n_exp = tlast_idx + 1; early_e = 1;
    end else begin
      n_exp = len; missing_e = (tlast_idx != len - 1);
    end
    exp_status = {8'd0, 16'(n_exp), 3'd0, aborted_e, missing_e, early_e, !aborted_e, 1'b0};
    base_field = 32'(base) << 16;

    host_req = 1'b0;
    axis.S_AXIS_TVALID = 1'b0;
    ctrl = base_field | (32'(len_m1) << 8) | 32'd1;
    tick();
    checkOutput("status_after_start", status, 32'h1);

    beat = 0; cycles = 0; finished = 0;
    while (!finished && cycles < 2000) begin
      cycles++;
      abort_now = (abort_after >= 0) && (beat == abort_after);
      host_req  = ($urandom_range(99) < host_pct);
      host_addr = (host_fixed >= 0) ? AW'(host_fixed) : AW'($urandom);
      tv = abort_now || (beat < n_exp && $urandom_range(99) < 70);
      axis.S_AXIS_TVALID = tv;
      axis.S_AXIS_TDATA  = $urandom;
      axis.S_AXIS_TSTRB  = SW'($urandom);
      axis.S_AXIS_TLAST  = (beat == tlast_idx);
      // Start toggles and len changes mid-burst must be ignored
      ctrl = base_field | (32'($urandom_range(255)) << 8)
           | 32'($urandom_range(1)) | (abort_now ? 32'd2 : 32'd0);
      if (host_req) pushHostRead(host_addr);
      acc = tv && !host_req && !abort_now;
      if (acc) begin
        pushBeat(base + AW'(beat), axis.S_AXIS_TDATA, axis.S_AXIS_TSTRB);
        beat++;
      end
      #1;
      checkOutput("tready", axis.S_AXIS_TREADY, !host_req && !abort_now);
      if (abort_now || (abort_after < 0 && acc && beat == n_exp)) finished = 1;
      @(posedge aclk);
      #1;
    end
    if (!finished) reportFail("burst_timeout", $sformatf("%0d of %0d beats", beat, n_exp));

    host_req = 1'b0;
    axis.S_AXIS_TVALID = 1'b0;
    axis.S_AXIS_TLAST  = 1'b0;
    ctrl = base_field;
    irq_expected++;
    checkOutput("irq_pulse", irq, 1'b1);
    checkOutput("tready_after", axis.S_AXIS_TREADY, 1'b0);
    tick();
    tick();
    checkOutput("final_status", status, exp_status);
    checkOutput("irq_count", irq_seen, irq_expected);
    checkOutput("writes_drained", exp_wr_q.size(), 0);
    checkOutput("reads_drained", exp_rd_data_q.size(), 0);
  endtask

  task automatic hostReadsIdle(input int n);
    for (int i = 0; i < n; i++) begin
      host_req  = 1'b1;
      host_addr = AW'($urandom);
      pushHostRead(host_addr);
      tick();
    end
    host_req = 1'b0;
    tick();
    tick();
    checkOutput("idle_reads_drained", exp_rd_data_q.size(), 0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_tready"}, axis.S_AXIS_TREADY, 1'b0);
    checkOutput({tag, "_tcm_en"}, tcm_en, 1'b0);
    checkOutput({tag, "_tcm_we"}, tcm_we, '0);
    checkOutput({tag, "_tcm_addr"}, tcm_addr, '0);
    checkOutput({tag, "_tcm_wdata"}, tcm_wdata, '0);
    checkOutput({tag, "_rvalid"}, host_rvalid, 1'b0);
    checkOutput({tag, "_rdata"}, host_rdata, '0);
    checkOutput({tag, "_irq"}, irq, 1'b0);
    checkOutput({tag, "_status"}, status, 32'h0);
  endtask

  initial begin
    int len_m1, tl, ab;
    areset = 1'b1;
    mem_init = 1'b1;
    ctrl = 32'h0;
    host_req = 1'b0;
    host_addr = '0;
    axis.S_AXIS_TVALID = 1'b0;
    axis.S_AXIS_TDATA  = '0;
    axis.S_AXIS_TSTRB  = '0;
    axis.S_AXIS_TLAST  = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = initWord(i);

    tick();
    tick();
    mem_init = 1'b0;
    checkResetOutputs("reset");
    areset = 1'b0;
    tick();

    hostReadsIdle(4);

    applyStimulus(10'h010, 3, 3, -1, 0, -1);     // nominal, writes 0x010..0x013
    applyStimulus(10'h020, 7, 2, -1, 20, -1);    // early TLAST
    applyStimulus(10'h040, 1, -1, -1, 20, -1);   // missing TLAST
    applyStimulus(10'h000, 5, 5, -1, 50, 10'h012); // host contention, clears flags
    applyStimulus(10'h3FE, 3, 3, -1, 20, -1);    // address wrap
    applyStimulus(10'h080, 7, -1, 2, 20, -1);    // abort after 2 beats

    // Start together with abort stays idle; offered beats must not be written
    ctrl = 32'h0000_0303;
    axis.S_AXIS_TVALID = 1'b1;
    tick();
    checkOutput("start_abort_busy", status[0], 1'b0);
    checkOutput("start_abort_tready", axis.S_AXIS_TREADY, 1'b0);
    ctrl = 32'h0;
    axis.S_AXIS_TVALID = 1'b0;
    tick();
    tick();

    for (int k = 0; k < 8; k++) begin
      len_m1 = ($urandom_range(9) == 0) ? 255 : $urandom_range(0, 20);
      tl = $urandom_range(0, len_m1 + 1);
      if (tl == len_m1 + 1) tl = -1;
      ab = -1;
      if (tl < 0 && $urandom_range(3) == 0) ab = $urandom_range(0, len_m1);
      applyStimulus(AW'($urandom), len_m1, tl, ab, $urandom_range(0, 40), -1);
    end

    // Reset in the middle of a burst
    ctrl = 32'h0100_0701;
    tick();
    for (int i = 0; i < 2; i++) begin
      ctrl = 32'h0100_0700;
      axis.S_AXIS_TVALID = 1'b1;
      axis.S_AXIS_TDATA  = $urandom;
      axis.S_AXIS_TSTRB  = '1;
      pushBeat(AW'(10'h100 + i), axis.S_AXIS_TDATA, axis.S_AXIS_TSTRB);
      #1;
      checkOutput("mid_tready", axis.S_AXIS_TREADY, 1'b1);
      @(posedge aclk);
      #1;
    end
    host_req = 1'b1;
    host_addr = 10'h155;
    areset = 1'b1;
    #1;
    checkResetOutputs("midreset");
    tick();
    exp_wr_q.delete();
    exp_rd_addr_q.delete();
    exp_rd_data_q.delete();
    host_req = 1'b0;
    axis.S_AXIS_TVALID = 1'b0;
    ctrl = 32'h0;
    areset = 1'b0;
    tick();
    checkOutput("post_reset_status", status, 32'h0);

    applyStimulus(10'h100, 3, 3, -1, 20, -1);
    hostReadsIdle(3);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
